// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   - state_e   : control FSM encoding (idle, debug read, debug ack, clear)
//   - rd_src_e  : source select for a registered read (array, write data, zero)
//   - rd_src()  : read-source decision shared by the pipeline ports and the
//                 debug read, so both apply identical zero/bypass rules
//   - NB_DATA_DEF / NB_ADDR_DEF : default widths used by the CPU top
package regfile_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_ADDR_DEF = 5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DBG_RD  = 2'd1,
    S_DBG_ACK = 2'd2,
    S_CLEAR   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_ARRAY = 2'd0,
    SRC_WDATA = 2'd1,
    SRC_ZERO  = 2'd2
  } rd_src_e;

  // Zero has priority over bypass: register 0 must read 0 even while a
  // (suppressed) write targets it. force_zero covers the clear sequence.
  function automatic rd_src_e rd_src(input logic zero_reg_en,
                                     input logic addr_is_zero,
                                     input logic bypass_en,
                                     input logic wr_hit,
                                     input logic force_zero);
    rd_src_e src;
    if (force_zero || (zero_reg_en && addr_is_zero)) begin
      src = SRC_ZERO;
    end else if (bypass_en && wr_hit) begin
      src = SRC_WDATA;
    end else begin
      src = SRC_ARRAY;
    end
    return src;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered pipeline read port.
//   clk, i_rst_n : clock, asynchronous active-low reset
//   i_stall      : hold o_data
//   i_clear      : clear sequence running; load 0
//   i_addr       : read address
//   i_arr_data   : array contents at i_addr (pre-write value)
//   i_wr_en      : qualified write enable (already excludes suppressed writes)
//   i_wr_addr    : write address
//   i_wr_data    : write data, forwarded when BYPASS and addresses match
//   o_data       : registered read data, latency 1
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int NB_ADDR  = NB_ADDR_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_clear,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_arr_data,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  output logic [NB_DATA-1:0] o_data
);

  rd_src_e            src;
  logic [NB_DATA-1:0] rd_data_p0;
  logic [NB_DATA-1:0] rd_data_p1;

  always_comb begin
    src = rd_src(ZERO_REG != 0, i_addr == '0, BYPASS != 0,
                 i_wr_en && (i_wr_addr == i_addr), i_clear);
    rd_data_p0 = i_arr_data;
    case (src)
      SRC_WDATA: rd_data_p0 = i_wr_data;
      SRC_ZERO:  rd_data_p0 = '0;
      default:   rd_data_p0 = i_arr_data;
    endcase
  end

  // ---- stage p0 -> p1: registered read ----
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_p1 <= '0;
    end else if (!i_stall) begin
      rd_data_p1 <= rd_data_p0;
    end
  end

  assign o_data = rd_data_p1;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file for the MIPS ID stage.
//   clk, i_rst_n               : clock, asynchronous active-low reset
//   i_we, i_wr_addr, i_wr_data : write port (from WB)
//   i_rd_addr, i_stall         : N_RD packed read addresses, read hold
//   o_rd_data                  : N_RD packed registered read data
//   i_dbg_req, i_dbg_addr      : four-phase debug read request
//   o_dbg_ack, o_dbg_data      : debug acknowledge and data
//   i_clr, o_busy              : clear request, clear-in-progress flag
// Clear zeroes one register per cycle; writes are dropped meanwhile, so the
// pipeline is expected to stall on o_busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int NB_ADDR  = NB_ADDR_DEF,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_we,
  input  logic [NB_ADDR-1:0]         i_wr_addr,
  input  logic [NB_DATA-1:0]         i_wr_data,
  input  logic [N_RD*NB_ADDR-1:0]    i_rd_addr,
  input  logic                       i_stall,
  output logic [N_RD*NB_DATA-1:0]    o_rd_data,
  input  logic                       i_dbg_req,
  input  logic [NB_ADDR-1:0]         i_dbg_addr,
  output logic                       o_dbg_ack,
  output logic [NB_DATA-1:0]         o_dbg_data,
  input  logic                       i_clr,
  output logic                       o_busy
);

  localparam int DEPTH  = 2 ** NB_ADDR;
  localparam int NB_CNT = NB_ADDR + 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(DEPTH - 1);

  logic [NB_DATA-1:0] regs [DEPTH];

  state_e             state_q, state_d;
  logic [NB_CNT-1:0]  clr_cnt_q, clr_cnt_d;
  logic [NB_ADDR-1:0] dbg_addr_q, dbg_addr_d;
  logic [NB_DATA-1:0] dbg_data_q, dbg_data_d;
  logic [NB_DATA-1:0] dbg_rd_val;
  rd_src_e            dbg_src;
  logic               clearing;
  logic               wr_en;

  assign clearing = (state_q == S_CLEAR);
  assign wr_en    = i_we && !clearing && !((ZERO_REG != 0) && (i_wr_addr == '0));

  // Array: clear sweep takes precedence; wr_en is already low while clearing.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (clearing) begin
      regs[clr_cnt_q[NB_ADDR-1:0]] <= '0;
    end else if (wr_en) begin
      regs[i_wr_addr] <= i_wr_data;
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [NB_ADDR-1:0] addr_k;
    logic [NB_DATA-1:0] arr_k;

    assign addr_k = i_rd_addr[k*NB_ADDR +: NB_ADDR];
    assign arr_k  = regs[addr_k];

    regfile_rd_port #(
      .NB_DATA  (NB_DATA),
      .NB_ADDR  (NB_ADDR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd_port (
      .clk        (clk),
      .i_rst_n    (i_rst_n),
      .i_stall    (i_stall),
      .i_clear    (clearing),
      .i_addr     (addr_k),
      .i_arr_data (arr_k),
      .i_wr_en    (wr_en),
      .i_wr_addr  (i_wr_addr),
      .i_wr_data  (i_wr_data),
      .o_data     (o_rd_data[k*NB_DATA +: NB_DATA])
    );
  end

  // Debug read value follows the same zero/bypass rules as the read ports.
  always_comb begin
    dbg_src = rd_src(ZERO_REG != 0, dbg_addr_q == '0, BYPASS != 0,
                     wr_en && (i_wr_addr == dbg_addr_q), 1'b0);
    dbg_rd_val = regs[dbg_addr_q];
    case (dbg_src)
      SRC_WDATA: dbg_rd_val = i_wr_data;
      SRC_ZERO:  dbg_rd_val = '0;
      default:   dbg_rd_val = regs[dbg_addr_q];
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      clr_cnt_q  <= '0;
      dbg_addr_q <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      dbg_addr_q <= dbg_addr_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  // Clear wins over a simultaneous debug request; a four-phase master keeps
  // i_dbg_req high, so the request is picked up on return to idle.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    dbg_addr_d = dbg_addr_q;
    dbg_data_d = dbg_data_q;
    case (state_q)
      S_IDLE: begin
        if (i_clr) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end else if (i_dbg_req) begin
          state_d    = S_DBG_RD;
          dbg_addr_d = i_dbg_addr;
        end
      end
      S_DBG_RD: begin
        dbg_data_d = dbg_rd_val;
        state_d    = S_DBG_ACK;
      end
      S_DBG_ACK: begin
        if (!i_dbg_req) begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_dbg_ack  = (state_q == S_DBG_ACK);
  assign o_dbg_data = dbg_data_q;
  assign o_busy     = clearing;

endmodule
